// File: rtl/systolic_array_ctrl.sv
// Sequencing controller for an N x N output-stationary MAC array: clears the
// accumulators, drives skewed per-lane feed enables, waits for drain, pulses done.
module systolic_array_ctrl #(
    parameter int N   = 4,
    parameter int K_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [K_W-1:0] k_len,
    output logic           busy,
    output logic           array_clr,
    output logic [N-1:0]   feed_valid,
    output logic [K_W:0]   step,
    output logic           done
);

    localparam int SW = K_W + 1;
    localparam int DW = $clog2(N);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [K_W-1:0]  k_r;
    logic [K_W-1:0]  k_nxt_s;
    logic [SW-1:0]   step_r;
    logic [SW-1:0]   step_nxt_s;
    logic [DW-1:0]   drain_r;
    logic [DW-1:0]   drain_nxt_s;
    logic [SW-1:0]   last_step_s;

    logic            busy_r;
    logic            busy_nxt_s;
    logic            clr_r;
    logic            clr_nxt_s;
    logic            done_r;
    logic            done_nxt_s;
    logic [N-1:0]    feed_r;
    logic [N-1:0]    feed_nxt_s;

    // Lane i is live for operand indices step-i in 0..k-1.
    function automatic logic [N-1:0] feed_mask(input logic [SW-1:0] s,
                                               input logic [K_W-1:0] k);
        logic [N-1:0]  m;
        logic [SW-1:0] lo;
        m = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            lo   = SW'(i);
            m[i] = (s >= lo) && (s < (lo + {1'b0, k}));
        end
        return m;
    endfunction

    assign last_step_s = {1'b0, k_r} + SW'(N - 2);

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            k_r     <= {K_W{1'b0}};
            step_r  <= {SW{1'b0}};
            drain_r <= {DW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            k_r     <= k_nxt_s;
            step_r  <= step_nxt_s;
            drain_r <= drain_nxt_s;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_nxt_s = state_r;
        k_nxt_s     = k_r;
        step_nxt_s  = step_r;
        drain_nxt_s = drain_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nxt_s = S_CLR;
                    k_nxt_s     = k_len;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_CLR: begin
                step_nxt_s  = {SW{1'b0}};
                drain_nxt_s = {DW{1'b0}};
                if (k_r != {K_W{1'b0}}) begin
                    state_nxt_s = S_FEED;
                end else begin
                    state_nxt_s = S_DRAIN;
                end
            end
            S_FEED: begin
                if (step_r == last_step_s) begin
                    state_nxt_s = S_DRAIN;
                    step_nxt_s  = {SW{1'b0}};
                    drain_nxt_s = {DW{1'b0}};
                end else begin
                    step_nxt_s  = step_r + {{(SW-1){1'b0}}, 1'b1};
                end
            end
            S_DRAIN: begin
                if (drain_r == DW'(N - 1)) begin
                    state_nxt_s = S_DONE;
                    drain_nxt_s = {DW{1'b0}};
                end else begin
                    drain_nxt_s = drain_r + {{(DW-1){1'b0}}, 1'b1};
                end
            end
            S_DONE: begin
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
                step_nxt_s  = {SW{1'b0}};
                drain_nxt_s = {DW{1'b0}};
            end
        endcase
    end

    // Output values for the upcoming cycle, decoded from the next state so the
    // registered outputs line up with the state they describe.
    always_comb begin
        busy_nxt_s = 1'b0;
        clr_nxt_s  = 1'b0;
        done_nxt_s = 1'b0;
        feed_nxt_s = {N{1'b0}};
        case (state_nxt_s)
            S_IDLE: begin
                busy_nxt_s = 1'b0;
            end
            S_CLR: begin
                busy_nxt_s = 1'b1;
                clr_nxt_s  = 1'b1;
            end
            S_FEED: begin
                busy_nxt_s = 1'b1;
                feed_nxt_s = feed_mask(step_nxt_s, k_nxt_s);
            end
            S_DRAIN: begin
                busy_nxt_s = 1'b1;
            end
            S_DONE: begin
                done_nxt_s = 1'b1;
            end
            default: begin
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            clr_r  <= 1'b0;
            done_r <= 1'b0;
            feed_r <= {N{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
            clr_r  <= clr_nxt_s;
            done_r <= done_nxt_s;
            feed_r <= feed_nxt_s;
        end
    end

    assign busy       = busy_r;
    assign array_clr  = clr_r;
    assign done       = done_r;
    assign feed_valid = feed_r;
    assign step       = step_r;

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Scoreboard bench for systolic_array_ctrl: a cycle-level reference model built
// from the operation's timeline formulas, with done pulses checked against a queue.
module tb_systolic_array_ctrl;

    localparam int N   = 4;
    localparam int K_W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [K_W-1:0] k_len;
    logic           busy;
    logic           array_clr;
    logic [N-1:0]   feed_valid;
    logic [K_W:0]   step;
    logic           done;

    int tests = 0;
    int fails = 0;
    int edge_cnt = 0;

    bit             act = 1'b0;
    int             e0 = 0;
    int             op_k = 0;
    int             lat = 0;
    logic           exp_busy = 1'b0;
    logic           exp_clr = 1'b0;
    logic           exp_done = 1'b0;
    logic [N-1:0]   exp_fv = '0;
    logic [K_W:0]   exp_step = '0;
    int             done_q[$];

    systolic_array_ctrl #(.N(N), .K_W(K_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .k_len      (k_len),
        .busy       (busy),
        .array_clr  (array_clr),
        .feed_valid (feed_valid),
        .step       (step),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Reference model: cycle c after acceptance edge E0 follows edge E0+c-1.
    initial begin
        forever begin
            int c;
            int s;
            @(posedge clk);
            edge_cnt = edge_cnt + 1;
            if (rst) begin
                act = 1'b0;
                done_q.delete();
            end else if (start && (!act || (edge_cnt - e0 >= lat + 1))) begin
                act  = 1'b1;
                e0   = edge_cnt;
                op_k = int'(k_len);
                lat  = (op_k == 0) ? (N + 2) : (op_k + 2 * N + 1);
                done_q.push_back(e0 + lat - 1);
            end
            exp_busy = 1'b0;
            exp_clr  = 1'b0;
            exp_done = 1'b0;
            exp_fv   = '0;
            exp_step = '0;
            if (act) begin
                c = edge_cnt - e0 + 1;
                if (c == 1) begin
                    exp_clr  = 1'b1;
                    exp_busy = 1'b1;
                end else if (c < lat) begin
                    exp_busy = 1'b1;
                    if (op_k > 0 && c <= op_k + N) begin
                        s = c - 2;
                        exp_step = (K_W + 1)'(s);
                        for (int i = 0; i < N; i++)
                            exp_fv[i] = (i <= s) && (s < i + op_k);
                    end
                end else if (c == lat) begin
                    exp_done = 1'b1;
                end
            end
        end
    end

    // Monitor: compares every cycle and pops the done scoreboard on each pulse.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tests++;
            if ({busy, array_clr, done, feed_valid, step} !==
                {exp_busy, exp_clr, exp_done, exp_fv, exp_step}) begin
                fails++;
                $display("FAIL outputs edge %0d: got busy=%b clr=%b done=%b fv=%b step=%0d, expected busy=%b clr=%b done=%b fv=%b step=%0d",
                         edge_cnt, busy, array_clr, done, feed_valid, step,
                         exp_busy, exp_clr, exp_done, exp_fv, exp_step);
            end
            if (done === 1'b1) begin
                tests++;
                if (done_q.size() == 0) begin
                    fails++;
                    $display("FAIL done_unexpected edge %0d: got done=1, expected no pending operation", edge_cnt);
                end else begin
                    int d;
                    d = done_q.pop_front();
                    if (d != edge_cnt) begin
                        fails++;
                        $display("FAIL done_time: got done at edge %0d, expected edge %0d", edge_cnt, d);
                    end
                end
            end
            while (done_q.size() > 0 && done_q[0] < edge_cnt) begin
                tests++;
                fails++;
                $display("FAIL done_missing: got no done by edge %0d, expected at edge %0d", edge_cnt, done_q[0]);
                void'(done_q.pop_front());
            end
        end
    end

    task automatic hold(input logic r, input logic s, input int k, input int n);
        rst   = r;
        start = s;
        k_len = K_W'(k);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        k_len = 8'd7;
        @(negedge clk);
        // reset with start asserted, then idle
        hold(1'b1, 1'b1, 7, 3);
        hold(1'b0, 1'b0, 7, 10);
        // nominal K=3
        hold(1'b0, 1'b1, 3, 1);
        hold(1'b0, 1'b0, 3, 15);
        // K=0
        hold(1'b0, 1'b1, 0, 1);
        hold(1'b0, 1'b0, 0, 10);
        // K=5: start pulses in FEED (cycle 4) and in DONE (cycle 14) are ignored
        hold(1'b0, 1'b1, 5, 1);
        hold(1'b0, 1'b0, 5, 3);
        hold(1'b0, 1'b1, 9, 1);
        hold(1'b0, 1'b0, 9, 9);
        hold(1'b0, 1'b1, 2, 1);
        hold(1'b0, 1'b0, 2, 5);
        // start held high: back-to-back operations
        hold(1'b0, 1'b1, 4, 40);
        hold(1'b0, 1'b0, 4, 10);
        // reset at FEED step=2 with K=8, then a fresh full operation
        hold(1'b0, 1'b1, 8, 1);
        hold(1'b0, 1'b0, 8, 3);
        hold(1'b1, 1'b0, 8, 1);
        hold(1'b0, 1'b0, 8, 5);
        hold(1'b0, 1'b1, 8, 1);
        hold(1'b0, 1'b0, 8, 25);
        // maximum K
        hold(1'b0, 1'b1, 255, 1);
        hold(1'b0, 1'b0, 255, 270);
        // randomized traffic with changing k_len and occasional reset
        repeat (3000) begin
            hold(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 20)),
                 1);
        end
        hold(1'b0, 1'b0, 0, 300);
        tests++;
        if (done_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending done entries, expected 0", done_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/systolic_array_ctrl.md
# systolic_array_ctrl

Sequencing controller for an N×N output-stationary array of 32-bit MAC processing elements. On a start request it clears every PE accumulator, drives per-lane skewed feed enables so row-operand lane i and column-operand lane i start i cycles after lane 0, waits for the wavefront to drain through the array, then pulses done when all N×N results are stable on the PE c outputs. It sits between the host/command logic and the operand feeders in front of the array.

## Interface
- N, 4: array dimension; number of row lanes and column lanes. Legal range 2..16.
- K_W, 8: width of the inner-dimension length k_len.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request a new matrix product; sampled only in IDLE.
- k_len  input  K_W  inner dimension K; latched when start is accepted.
- busy  output  1  high in CLR, FEED, DRAIN.
- array_clr  output  1  one-cycle accumulator clear to all PEs (drives PE reset).
- feed_valid  output  N  bit i enables row lane i and column lane i this cycle.
- step  output  K_W+1  FEED-phase cycle index; operand index for lane i is step−i.
- done  output  1  one-cycle pulse; array results valid this cycle.

## Operation
- States: IDLE, CLR, FEED, DRAIN, DONE.
- IDLE: start=1 → latch k_len into k_reg, go to CLR. start=0 → stay.
- CLR: array_clr=1 for exactly one cycle. Next: FEED if k_reg≠0, else DRAIN.
- FEED: step counts 0..k_reg+N−2, one per cycle. feed_valid[i]=1 iff i ≤ step < i+k_reg. After step=k_reg+N−2 → DRAIN, step returns to 0.
- DRAIN: internal drain counter runs N cycles (N−1 cycles of PE-to-PE propagation plus 1 cycle for the PE output register), then → DONE.
- DONE: done=1 for one cycle, → IDLE.
- start is ignored in CLR, FEED, DRAIN, DONE. A new start is not queued.
- k_reg is held constant from acceptance to DONE. Changes on k_len after acceptance have no effect.
- step width K_W+1 holds k_reg+N−2 without wrap for every legal N and K. All comparisons are unsigned at that width.
- rst=1 at any edge, including mid-FEED or mid-DRAIN:
  - next state is IDLE; step, k_reg and drain counter go to 0.
  - The active operation is abandoned and no done is produced.
  - The array is not cleared by rst itself; the next accepted start issues array_clr.

## Timing
- Reset values: busy=0, array_clr=0, feed_valid=0, step=0, done=0, state=IDLE.
- All outputs are registered. None depends combinationally on start or k_len.
- Start accepted at edge E0. Then:
  - cycle 1: array_clr=1, busy=1.
  - cycles 2..K+N: FEED.
  - cycles K+N+1..K+2N: DRAIN.
  - cycle K+2N+1: done=1, busy=0.
- Total latency is start-to-done = K+2N+1 cycles. For K=0: CLR, then N DRAIN cycles, done at cycle N+2.
- busy and done are never high in the same cycle.
- The earliest next acceptance is the start sampled in the cycle after DONE (back-to-back throughput K+2N+2 cycles).
- feed_valid[0] is high on FEED cycles 2..K+1. feed_valid[N−1] is high on cycles N+1..K+N.

## Test plan
- Reset, then idle: hold rst 3 cycles with start=1 → all outputs 0. Release with start=0 → stays IDLE, busy=0 indefinitely.
- Nominal N=4, K=3, start at E0:
  - array_clr only at cycle 1.
  - feed_valid: 0001 at cycle 2, 0011 at 3, 0111 at 4, 1110 at 5, 1100 at 6, 1000 at 7.
  - step 0..5 over cycles 2..7.
  - done only at cycle 12; busy high cycles 1..11.
- K=0, N=4: array_clr at cycle 1, feed_valid stays 0, done at cycle 6.
- Start ignored while busy: pulse start during FEED and during DONE with different k_len → no restart, k_reg unchanged, exactly one done. Start held high through DONE → second operation accepted the cycle after DONE.
- Reset mid-operation: assert rst at FEED step=2 (N=4, K=8) → next cycle IDLE, all outputs 0, no done ever. A fresh start → array_clr reissued, full sequence with the correct timing.
- Maximum K: K_W=8, K=255, N=4 → step reaches 257 with no wrap, feed_valid[3] deasserts after step=257, done at cycle 264.
